// File: rtl/writeback_stage_if.sv
// Writeback stage bus: MEM-side capture inputs, MDU handshake, register
// file write port and pending-buffer status. The read-bypass signals exist
// only when WB_BYPASS_EN is defined.
// master: the surrounding pipeline / register file; slave: writeback_stage.
interface writeback_stage_if #(
    parameter int WIDTH = 32,
    parameter int RSELW = 5
);
    // MEM stage outputs captured by the WB latch
    logic             mem_valid;
    logic             mem_regwen;
    logic             mem_memtoreg;
    logic [RSELW-1:0] mem_wsel;
    logic [WIDTH-1:0] mem_result;
    logic [WIDTH-1:0] mem_dload;
    logic             wb_stall;
    logic             wb_flush;

    // Multicycle mult/div unit result handshake
    logic             mdu_valid;
    logic [RSELW-1:0] mdu_wsel;
    logic [WIDTH-1:0] mdu_wdat;
    logic             mdu_ready;

    // Register file write port
    logic             rf_wen;
    logic [RSELW-1:0] rf_wsel;
    logic [WIDTH-1:0] rf_wdat;

    // Pending buffer status for the hazard unit
    logic             pend_valid;
    logic [RSELW-1:0] pend_wsel;

`ifdef WB_BYPASS_EN
    // Same-cycle write-to-read bypass
    logic [RSELW-1:0] rsel1;
    logic [RSELW-1:0] rsel2;
    logic [WIDTH-1:0] rf_rdat1;
    logic [WIDTH-1:0] rf_rdat2;
    logic [WIDTH-1:0] byp_rdat1;
    logic [WIDTH-1:0] byp_rdat2;
`endif

    modport master (
        output mem_valid, mem_regwen, mem_memtoreg, mem_wsel, mem_result, mem_dload,
        output wb_stall, wb_flush,
        output mdu_valid, mdu_wsel, mdu_wdat,
        input  mdu_ready,
        input  rf_wen, rf_wsel, rf_wdat,
        input  pend_valid, pend_wsel
`ifdef WB_BYPASS_EN
        ,
        output rsel1, rsel2, rf_rdat1, rf_rdat2,
        input  byp_rdat1, byp_rdat2
`endif
    );

    modport slave (
        input  mem_valid, mem_regwen, mem_memtoreg, mem_wsel, mem_result, mem_dload,
        input  wb_stall, wb_flush,
        input  mdu_valid, mdu_wsel, mdu_wdat,
        output mdu_ready,
        output rf_wen, rf_wsel, rf_wdat,
        output pend_valid, pend_wsel
`ifdef WB_BYPASS_EN
        ,
        input  rsel1, rsel2, rf_rdat1, rf_rdat2,
        output byp_rdat1, byp_rdat2
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline latch and sole owner of the register file write port.
// Merges in-order pipeline writes with out-of-order MDU results; an MDU
// result that collides with a pipeline write is parked in a one-entry
// pending buffer and drained into the next cycle without a pipeline write.
// Optional macro WB_BYPASS_EN adds a combinational write-to-read bypass.
module writeback_stage #(
    parameter int WIDTH = 32,
    parameter int RSELW = 5
) (
    input logic             CLK,
    input logic             RST,
    writeback_stage_if.slave bus
);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [RSELW-1:0] rsel_t;

    typedef struct packed {
        logic  valid;
        logic  regwen;
        logic  memtoreg;
        rsel_t wsel;
    } wb_ctrl_t;

    wb_ctrl_t ctrl_q;
    word_t    result_q;
    word_t    dload_q;

    logic     pend_valid_q;
    rsel_t    pend_wsel_q;
    word_t    pend_wdat_q;

    logic     pwr;
    word_t    pipe_wdat;
    logic     mdu_accept;
    logic     mdu_direct;
    logic     pend_load;
    logic     pend_clear;
    logic     port_wen;
    rsel_t    port_wsel;
    word_t    port_wdat;

    // Control half of the WB latch; flush beats stall.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // the pre-edge values regardless of block ordering.
        if (RST) begin
            ctrl_q <= '0;
        end else if (bus.wb_flush) begin
            ctrl_q.valid <= 1'b0;
        end else if (!bus.wb_stall) begin
            ctrl_q <= '{valid:    bus.mem_valid,
                        regwen:   bus.mem_regwen,
                        memtoreg: bus.mem_memtoreg,
                        wsel:     bus.mem_wsel};
        end
    end

    // Data half of the WB latch; captured alongside the control half.
    always_ff @(posedge CLK) begin
        // NOTE: data words carry no reset; they are only consumed while the
        // matching valid bit (which is reset) says they are meaningful.
        if (!bus.wb_stall) begin
            result_q <= bus.mem_result;
            dload_q  <= bus.mem_dload;
        end
    end

    // Pipeline write request and source selection, straight from the latch.
    always_comb begin
        pwr       = ctrl_q.valid & ctrl_q.regwen & (ctrl_q.wsel != '0);
        pipe_wdat = ctrl_q.memtoreg ? dload_q : result_q;
    end

    // MDU acceptance and pending-buffer load/clear decisions.
    always_comb begin
        mdu_accept = bus.mdu_valid & ~pend_valid_q;
        // Gated by RST so the port stays quiet while reset is held.
        mdu_direct = mdu_accept & (bus.mdu_wsel != '0) & ~RST;
        // A same-destination MDU result is older than the pipeline write, so
        // it is dropped rather than parked.
        pend_load  = mdu_accept & pwr & (bus.mdu_wsel != '0) &
                     (bus.mdu_wsel != ctrl_q.wsel);
        // Drain on a free slot, or drop when the pipeline overwrites it.
        pend_clear = pend_valid_q & (~pwr | (pend_wsel_q == ctrl_q.wsel));
    end

    // Pending buffer occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_valid_q <= 1'b0;
        end else if (pend_load) begin
            pend_valid_q <= 1'b1;
        end else if (pend_clear) begin
            pend_valid_q <= 1'b0;
        end
    end

    // Pending buffer payload.
    always_ff @(posedge CLK) begin
        if (pend_load) begin
            pend_wsel_q <= bus.mdu_wsel;
            pend_wdat_q <= bus.mdu_wdat;
        end
    end

    // Write port arbitration: pipeline, then pending, then direct MDU.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        port_wen  = 1'b0;
        port_wsel = '0;
        port_wdat = '0;
        if (pwr) begin
            port_wen  = 1'b1;
            port_wsel = ctrl_q.wsel;
            port_wdat = pipe_wdat;
        end else if (pend_valid_q) begin
            port_wen  = 1'b1;
            port_wsel = pend_wsel_q;
            port_wdat = pend_wdat_q;
        end else if (mdu_direct) begin
            port_wen  = 1'b1;
            port_wsel = bus.mdu_wsel;
            port_wdat = bus.mdu_wdat;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.rf_wen     = port_wen;
        bus.rf_wsel    = port_wsel;
        bus.rf_wdat    = port_wdat;
        bus.mdu_ready  = ~pend_valid_q;
        bus.pend_valid = pend_valid_q;
        bus.pend_wsel  = pend_valid_q ? pend_wsel_q : '0;
    end

`ifdef WB_BYPASS_EN
    // Forward the write in flight to matching reads; r0 is never forwarded.
    always_comb begin
        bus.byp_rdat1 = bus.rf_rdat1;
        bus.byp_rdat2 = bus.rf_rdat2;
        if (port_wen && (port_wsel == bus.rsel1) && (bus.rsel1 != '0)) begin
            bus.byp_rdat1 = port_wdat;
        end
        if (port_wen && (port_wsel == bus.rsel2) && (bus.rsel2 != '0)) begin
            bus.byp_rdat2 = port_wdat;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_writeback_stage;

    localparam int WIDTH = 32;
    localparam int RSELW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if #(.WIDTH(WIDTH), .RSELW(RSELW)) bus ();

    writeback_stage #(.WIDTH(WIDTH), .RSELW(RSELW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the architectural WB latch and a pending queue.
    typedef struct {
        bit        valid;
        bit        regwen;
        bit        memtoreg;
        bit [4:0]  wsel;
        bit [31:0] result;
        bit [31:0] dload;
    } latch_t;

    typedef struct {
        bit [4:0]  wsel;
        bit [31:0] wdat;
    } wr_t;

    latch_t m_latch;
    wr_t    m_pend[$];
    bit     seen_beef;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_port(input string tag, input bit wen, input bit [4:0] sel, input bit [31:0] dat);
        check({tag, "_wen"},  32'(bus.rf_wen),  32'(wen));
        check({tag, "_wsel"}, 32'(bus.rf_wsel), 32'(sel));
        check({tag, "_wdat"}, bus.rf_wdat,      dat);
    endtask

    task automatic set_mem(input bit v, input bit rw, input bit m2r, input bit [4:0] sel,
                           input bit [31:0] res, input bit [31:0] ld);
        bus.mem_valid    = v;
        bus.mem_regwen   = rw;
        bus.mem_memtoreg = m2r;
        bus.mem_wsel     = sel;
        bus.mem_result   = res;
        bus.mem_dload    = ld;
    endtask

    task automatic set_mdu(input bit v, input bit [4:0] sel, input bit [31:0] dat);
        bus.mdu_valid = v;
        bus.mdu_wsel  = sel;
        bus.mdu_wdat  = dat;
    endtask

    task automatic model_reset();
        m_latch.valid = 1'b0;
        m_pend.delete();
    endtask

    // One clock: compare outputs at the falling edge, advance model at the
    // rising edge, return 1 time unit after it.
    task automatic step();
        bit        pw;
        bit        exp_wen;
        bit [4:0]  exp_sel;
        bit [31:0] exp_dat;
        @(negedge clk);
        pw      = m_latch.valid && m_latch.regwen && (m_latch.wsel != 0);
        exp_wen = 1'b0;
        exp_sel = '0;
        exp_dat = '0;
        if (pw) begin
            exp_wen = 1'b1;
            exp_sel = m_latch.wsel;
            exp_dat = m_latch.memtoreg ? m_latch.dload : m_latch.result;
        end else if (m_pend.size() != 0) begin
            exp_wen = 1'b1;
            exp_sel = m_pend[0].wsel;
            exp_dat = m_pend[0].wdat;
        end else if (bus.mdu_valid && bus.mdu_wsel != 0) begin
            exp_wen = 1'b1;
            exp_sel = bus.mdu_wsel;
            exp_dat = bus.mdu_wdat;
        end
        expect_port("model", exp_wen, exp_sel, exp_dat);
        check("model_mdu_ready",  32'(bus.mdu_ready),  32'(m_pend.size() == 0));
        check("model_pend_valid", 32'(bus.pend_valid), 32'(m_pend.size() != 0));
        if (m_pend.size() != 0)
            check("model_pend_wsel", 32'(bus.pend_wsel), 32'(m_pend[0].wsel));
`ifdef WB_BYPASS_EN
        check("model_byp1", bus.byp_rdat1,
              (exp_wen && exp_sel == bus.rsel1 && bus.rsel1 != 0) ? exp_dat : bus.rf_rdat1);
        check("model_byp2", bus.byp_rdat2,
              (exp_wen && exp_sel == bus.rsel2 && bus.rsel2 != 0) ? exp_dat : bus.rf_rdat2);
`endif
        if (bus.rf_wen && bus.rf_wdat == 32'hBEEF) seen_beef = 1'b1;
        @(posedge clk);
        if (m_pend.size() != 0) begin
            if (!pw || m_pend[0].wsel == m_latch.wsel) void'(m_pend.pop_front());
        end else if (bus.mdu_valid && bus.mdu_wsel != 0 && pw && bus.mdu_wsel != m_latch.wsel) begin
            m_pend.push_back('{wsel: bus.mdu_wsel, wdat: bus.mdu_wdat});
        end
        if (bus.wb_flush) begin
            m_latch.valid = 1'b0;
        end else if (!bus.wb_stall) begin
            m_latch = '{valid: bus.mem_valid, regwen: bus.mem_regwen,
                        memtoreg: bus.mem_memtoreg, wsel: bus.mem_wsel,
                        result: bus.mem_result, dload: bus.mem_dload};
        end
        #1;
    endtask

    initial begin
        m_latch   = '{default: '0};
        seen_beef = 1'b0;
        rst = 1'b1;
        set_mem(0, 0, 0, 0, 0, 0);
        set_mdu(1, 5'd2, 32'h1111);
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;
`ifdef WB_BYPASS_EN
        bus.rsel1 = '0; bus.rsel2 = '0; bus.rf_rdat1 = '0; bus.rf_rdat2 = '0;
`endif

        // Reset state, with an MDU result already offered.
        #2;
        expect_port("reset", 0, 0, 0);
        check("reset_pend_valid", 32'(bus.pend_valid), 32'd0);
        check("reset_pend_wsel",  32'(bus.pend_wsel),  32'd0);
        check("reset_mdu_ready",  32'(bus.mdu_ready),  32'd1);
        set_mdu(0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Pipeline writes: ALU result, load data, r0 suppressed.
        set_mem(1, 1, 0, 5'd5, 32'h1234, 32'h0);
        step();
        set_mem(1, 1, 1, 5'd6, 32'h0, 32'hCAFE);
        #1 expect_port("pipe_alu", 1, 5'd5, 32'h1234);
        step();
        set_mem(1, 1, 0, 5'd0, 32'h55, 32'h0);
        #1 expect_port("pipe_load", 1, 5'd6, 32'hCAFE);
        step();
        set_mem(0, 0, 0, 0, 0, 0);
        #1 expect_port("pipe_r0", 0, 0, 0);
        step();

        // Collision: pipeline r3 with MDU r7 parked, then drained.
        set_mem(1, 1, 0, 5'd3, 32'h33, 32'h0);
        step();
        set_mem(0, 0, 0, 0, 0, 0);
        set_mdu(1, 5'd7, 32'hBEEF);
        #1 expect_port("coll_pipe", 1, 5'd3, 32'h33);
        check("coll_ready_before", 32'(bus.mdu_ready), 32'd1);
        step();
        set_mdu(0, 0, 0);
        #1;
        check("coll_pend_valid", 32'(bus.pend_valid), 32'd1);
        check("coll_pend_wsel",  32'(bus.pend_wsel),  32'd7);
        check("coll_ready_busy", 32'(bus.mdu_ready),  32'd0);
        expect_port("coll_drain", 1, 5'd7, 32'hBEEF);
        step();
        check("coll_pend_freed", 32'(bus.pend_valid), 32'd0);
        check("coll_ready_after", 32'(bus.mdu_ready), 32'd1);
        expect_port("coll_done", 0, 0, 0);

        // WAW: parked r7 overwritten by a younger pipeline write to r7.
        seen_beef = 1'b0;
        set_mem(1, 1, 0, 5'd3, 32'h33, 32'h0);
        step();
        set_mem(1, 1, 0, 5'd7, 32'h1, 32'h0);
        set_mdu(1, 5'd7, 32'hBEEF);
        step();
        set_mem(0, 0, 0, 0, 0, 0);
        set_mdu(0, 0, 0);
        #1 expect_port("waw_pipe", 1, 5'd7, 32'h1);
        check("waw_pend_held", 32'(bus.pend_valid), 32'd1);
        step();
        check("waw_pend_dropped", 32'(bus.pend_valid), 32'd0);
        expect_port("waw_after", 0, 0, 0);
        step();
        check("waw_no_beef", 32'(seen_beef), 32'd0);

        // Stall holds r9 for three cycles; stall+flush clears it.
        set_mem(1, 1, 0, 5'd9, 32'h99, 32'h0);
        step();
        set_mem(1, 1, 0, 5'd10, 32'hAA, 32'h0);
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 expect_port("stall_hold", 1, 5'd9, 32'h99);
            step();
        end
        expect_port("stall_last", 1, 5'd9, 32'h99);
        bus.wb_flush = 1'b1;
        step();
        bus.wb_stall = 1'b0;
        bus.wb_flush = 1'b0;
        set_mem(0, 0, 0, 0, 0, 0);
        #1 expect_port("flush", 0, 0, 0);
        step();

        // Asynchronous reset with the pending buffer occupied.
        set_mem(1, 1, 0, 5'd3, 32'h33, 32'h0);
        step();
        set_mem(1, 1, 0, 5'd12, 32'hC, 32'h0);
        set_mdu(1, 5'd7, 32'hBEEF);
        step();
        set_mdu(0, 0, 0);
        #1 check("rst_pre_pend", 32'(bus.pend_valid), 32'd1);
        rst = 1'b1;
        model_reset();
        #1;
        expect_port("rst_async", 0, 0, 0);
        check("rst_async_pend",  32'(bus.pend_valid), 32'd0);
        check("rst_async_ready", 32'(bus.mdu_ready),  32'd1);
        set_mem(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 expect_port("rst_idle", 0, 0, 0);
        set_mem(1, 1, 0, 5'd13, 32'hD, 32'h0);
        step();
        set_mem(0, 0, 0, 0, 0, 0);
        #1 expect_port("rst_new", 1, 5'd13, 32'hD);
        step();

`ifdef WB_BYPASS_EN
        // Bypass: live write to r4 forwarded, r0 read never forwarded.
        set_mem(1, 1, 0, 5'd4, 32'hAA, 32'h0);
        step();
        set_mem(0, 0, 0, 0, 0, 0);
        bus.rsel1 = 5'd4; bus.rf_rdat1 = 32'h0;
        bus.rsel2 = 5'd0; bus.rf_rdat2 = 32'h77;
        set_mdu(1, 5'd0, 32'h5);
        #1;
        check("byp_hit",  bus.byp_rdat1, 32'hAA);
        check("byp_r0",   bus.byp_rdat2, 32'h77);
        step();
        set_mdu(0, 0, 0);
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom),
                    5'($urandom_range(0, 7)), $urandom, $urandom);
            set_mdu($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom);
            bus.wb_stall = ($urandom_range(0, 9) < 2);
            bus.wb_flush = ($urandom_range(0, 19) == 0);
`ifdef WB_BYPASS_EN
            bus.rsel1 = 5'($urandom_range(0, 7));
            bus.rsel2 = 5'($urandom_range(0, 7));
            bus.rf_rdat1 = $urandom;
            bus.rf_rdat2 = $urandom;
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline latch for the pipelined CPU. Owns the single register file write port: drives WEN/wsel/wdat into register_file_if.
- Merges two write sources: in-order pipeline results (ALU or load) and out-of-order results from the multicycle mult/div unit (MDU).
- MDU writes that collide with a pipeline write are parked in a one-entry pending buffer and drained into the next free write slot.

Parameters:
- WIDTH, 32, data word width (word_t).
- RSELW, 5, register select width (32 registers; register 0 is hardwired zero).

Ports:
- CLK  in  1  clock; one clock for the whole block
- RST  in  1  reset; asynchronous, active-high
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_regwen  in  1  instruction writes a register
- mem_memtoreg  in  1  1 = write load data, 0 = write ALU result
- mem_wsel  in  RSELW  destination register
- mem_result  in  WIDTH  ALU result
- mem_dload  in  WIDTH  load data
- wb_stall  in  1  hold the WB latch contents
- wb_flush  in  1  invalidate the WB latch
- mdu_valid  in  1  MDU result available
- mdu_wsel  in  RSELW  MDU destination register
- mdu_wdat  in  WIDTH  MDU result
- mdu_ready  out  1  MDU result accepted this cycle when high with mdu_valid
- rf_wen  out  1  to register_file_if WEN
- rf_wsel  out  RSELW  to register_file_if wsel
- rf_wdat  out  WIDTH  to register_file_if wdat
- pend_valid  out  1  pending buffer occupied (to hazard unit)
- pend_wsel  out  RSELW  pending destination (to hazard unit)

Behaviour:
- Reset (async, RST=1): latch valid = 0, pending valid = 0. Outputs: rf_wen=0, rf_wsel=0, rf_wdat=0, pend_valid=0, pend_wsel=0, mdu_ready=1.
- Latch update at posedge CLK:
  - wb_flush: valid <= 0.
  - else if !wb_stall: capture mem_valid, mem_regwen, mem_memtoreg, mem_wsel, mem_result, mem_dload.
  - else (stall): hold.
  - wb_flush takes priority over wb_stall.
- Pipeline write request, combinational from latch: pwr = valid & regwen & (wsel != 0). Write data = memtoreg ? dload : result.
- While stalled, the latched write is re-presented every cycle. This is idempotent.
- Write port priority, combinational, one write per cycle:
  1. pwr: port takes the pipeline write.
  2. else pending valid: port takes the pending entry; pending clears at the edge.
  3. else mdu_valid & mdu_wsel != 0: port takes the MDU result directly (zero added latency).
  4. else rf_wen=0, rf_wsel=0, rf_wdat=0.
- mdu_ready = !pending valid.
  - Accepted MDU result with mdu_wsel = 0: consumed and discarded.
  - Accepted MDU result while pwr = 1: stored to pending. If mdu_wsel equals the pipeline wsel, discard it instead (the pipeline write is younger).
- WAW rule: while pending is valid and pwr writes the same wsel, pending is dropped at that edge. It is never written.
- Pending drained in case 2 frees the buffer at the edge. mdu_ready rises the following cycle, so there is no same-cycle refill.
- Latency:
  - Pipeline data reaches the register file on the cycle after capture.
  - An MDU result arriving with a free port is written in its arrival cycle.
  - A collided MDU result is written at the earliest cycle with pwr = 0.
- Reset mid-operation drops both the latch and pending contents. A partially accepted MDU handshake is lost; the MDU is reset by the same RST.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, adds these ports:
  - rsel1, rsel2: in, RSELW, read selects.
  - rf_rdat1, rf_rdat2: in, WIDTH, raw register file read data.
  - byp_rdat1, byp_rdat2: out, WIDTH, bypassed read data.
- byp_rdatN = (rf_wen & rf_wsel == rselN & rselN != 0) ? rf_wdat : rf_rdatN. This gives write-then-read-in-same-cycle semantics, purely combinational.
- When undefined, these ports do not exist. Decode must stall one cycle on a same-cycle write/read match.

Test Plan:
- Reset: RST=1 mid-stream with pending occupied -> rf_wen=0, pend_valid=0, mdu_ready=1 immediately (async); after deassert, first write occurs only from newly captured data.
- Pipeline write: mem_valid=1, regwen=1, wsel=5, result=0x1234, memtoreg=0 -> next cycle rf_wen=1, wsel=5, wdat=0x1234. Repeat with memtoreg=1, dload=0xCAFE -> wdat=0xCAFE. wsel=0 -> rf_wen=0.
- Collision: pipeline writes r3 while mdu_valid writes r7=0xBEEF -> cycle 0 writes r3, pend_valid=1, pend_wsel=7, mdu_ready=0. First cycle with pwr=0 writes r7=0xBEEF; mdu_ready=1 the following cycle.
- WAW drop: pending r7, then pipeline writes r7=0x1 -> r7 written 0x1 once, pend_valid=0 after edge, 0xBEEF never appears on rf_wdat.
- Stall/flush: wb_stall=1 for 3 cycles holds write r9 presented every cycle. wb_stall=1 & wb_flush=1 -> valid cleared, rf_wen=0 next cycle.
- WB_BYPASS_EN: rf_wen writes r4=0xAA, rsel1=4, rf_rdat1=0x0 -> byp_rdat1=0xAA. rsel2=0 with write to r0 attempted -> byp_rdat2=rf_rdat2.
